// File: rtl/output_stage_pkg.sv
// Shared encodings for the synthesizer output register stage: signal types,
// FSM states, default sample width and the start-request priority helper.
package output_stage_pkg;

  localparam int DATA_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    SIG_NONE  = 2'd0,
    SIG_LFM   = 2'd1,
    SIG_PSK   = 2'd2,
    SIG_NOISE = 2'd3
  } sig_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Simultaneous start requests resolve LFM first, then PSK, then NOISE.
  function automatic sig_type_e pick_type(input logic lfm, input logic psk, input logic noise);
    if (lfm)        return SIG_LFM;
    else if (psk)   return SIG_PSK;
    else if (noise) return SIG_NOISE;
    else            return SIG_NONE;
  endfunction

endpackage

// File: rtl/output_stage_delay_counter.sv
// Load/clear/enable up-counter with a latched limit; tc_o is high while the
// count equals the limit, and the count holds there until cleared.
module output_stage_delay_counter #(
  parameter int DLY_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DLY_W-1:0] limit_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [DLY_W-1:0] limit_q, limit_d;
  logic [DLY_W-1:0] count_q, count_d;

  assign tc_o = (count_q == limit_q);

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    limit_d = limit_q;
    count_d = count_q;
    if (load_i) limit_d = limit_i;
    if (clr_i)              count_d = '0;
    else if (en_i && !tc_o) count_d = count_q + DLY_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/output_stage.sv
// Output register stage between the waveform generators and the DAC bus.
// OUTPUT_STAGE_HIZ_EN selects a tri-stated idle bus instead of all-zero.
module output_stage
  import output_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DLY_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DLY_W-1:0]  START_DLY,
  input  logic [DLY_W-1:0]  STOP_DLY,
  input  logic              SIGN_LFM_START_CALC,
  input  logic              SIGN_PSK_START_CALC,
  input  logic              SIGN_NOISE_START_CALC,
  input  logic              SIGN_LFM_STOP_CALC,
  input  logic              SIGN_PSK_STOP_CALC,
  input  logic              SIGN_NOISE_STOP_CALC,
  input  logic              ABORT,
  input  logic [DATA_W-1:0] DATA_FROM_ROM,
  input  logic [DATA_W-1:0] DATA_FROM_FIFO,
  input  logic              FIFO_EMPTY,
  output logic              READY,
  output logic              FIFO_REQ,
  output logic              OUT_VALID,
  output logic              UNDERFLOW,
  output logic [CNT_W-1:0]  SAMPLE_CNT,
  output logic [DATA_W-1:0] REG_OUT
);

  state_e            state_q, state_d;
  sig_type_e         type_q, type_d;
  logic              started_q, started_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              idle_q, idle_d;
  logic              valid_q, valid_d;
  logic              under_q, under_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic             any_start, any_stop, accept;
  logic             sampling, ending, sample_now, stop_clr;
  logic             start_tc, stop_tc;
  logic [DLY_W-1:0] start_lim;

  assign any_start = SIGN_LFM_START_CALC | SIGN_PSK_START_CALC | SIGN_NOISE_START_CALC;
  assign any_stop  = SIGN_LFM_STOP_CALC  | SIGN_PSK_STOP_CALC  | SIGN_NOISE_STOP_CALC;
  assign accept    = (state_q == ST_IDLE) && any_start;
  assign stop_clr  = ((state_q == ST_ARM) || (state_q == ST_RUN)) && any_stop;

  // The start counter matches at D-1 so the ARM->RUN edge lands exactly D edges after start.
  assign start_lim = (START_DLY == '0) ? '0 : START_DLY - DLY_W'(1);

  assign sampling   = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && started_q);
  assign ending     = (state_q == ST_DRAIN) && stop_tc;
  assign sample_now = sampling && !ending;

  output_stage_delay_counter #(.DLY_W(DLY_W)) u_start_cnt (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (accept),
    .limit_i (start_lim),
    .clr_i   (accept),
    .en_i    ((state_q == ST_ARM) || (state_q == ST_DRAIN)),
    .tc_o    (start_tc)
  );

  output_stage_delay_counter #(.DLY_W(DLY_W)) u_stop_cnt (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (accept),
    .limit_i (STOP_DLY),
    .clr_i   (stop_clr),
    .en_i    (state_q == ST_DRAIN),
    .tc_o    (stop_tc)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    started_d = started_q;
    data_d    = data_q;
    idle_d    = idle_q;
    valid_d   = 1'b0;
    under_d   = under_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: if (any_start) begin
        state_d   = ST_ARM;
        type_d    = pick_type(SIGN_LFM_START_CALC, SIGN_PSK_START_CALC, SIGN_NOISE_START_CALC);
        started_d = 1'b0;
        under_d   = 1'b0;
        cnt_d     = '0;
      end
      ST_ARM: begin
        started_d = start_tc;
        if (any_stop)      state_d = ST_DRAIN;
        else if (start_tc) state_d = ST_RUN;
      end
      ST_RUN:   if (any_stop) state_d = ST_DRAIN;
      ST_DRAIN: begin
        started_d = started_q | start_tc;
        if (stop_tc) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (ABORT && (state_q != ST_IDLE)) state_d = ST_IDLE;

    // An empty noise FIFO leaves the bus and count untouched for that sample slot.
    if (state_d == ST_IDLE) begin
      idle_d = 1'b1;
    end else if (sample_now) begin
      if ((type_q == SIG_NOISE) && FIFO_EMPTY) begin
        under_d = 1'b1;
      end else begin
        data_d  = (type_q == SIG_NOISE) ? DATA_FROM_FIFO : DATA_FROM_ROM;
        idle_d  = 1'b0;
        valid_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      idle_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      type_q    <= SIG_NONE;
      started_q <= 1'b0;
      data_q    <= '0;
      idle_q    <= 1'b1;
      valid_q   <= 1'b0;
      under_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      started_q <= started_d;
      data_q    <= data_d;
      idle_q    <= idle_d;
      valid_q   <= valid_d;
      under_q   <= under_d;
      cnt_q     <= cnt_d;
    end
  end

  assign READY      = (state_q == ST_IDLE);
  assign FIFO_REQ   = sampling && (type_q == SIG_NOISE);
  assign OUT_VALID  = valid_q;
  assign UNDERFLOW  = under_q;
  assign SAMPLE_CNT = cnt_q;

`ifdef OUTPUT_STAGE_HIZ_EN
  assign REG_OUT = idle_q ? {DATA_W{1'bz}} : data_q;
`else
  assign REG_OUT = idle_q ? '0 : data_q;
`endif

endmodule
